// File: rtl/led_panel_receiver_pkg.sv
// Shared LED panel definitions: geometry defaults, FM6126 latch counts, FSM encoding, pixel payload.
package led_panel_receiver_pkg;

  localparam int unsigned PANEL_W_DEF = 64;
  localparam int unsigned RGB_W       = 3;
  localparam int unsigned ADDR_W      = 5;
  localparam int unsigned X_W         = 6;
  localparam int unsigned REG_W       = 16;
  localparam int unsigned COL_CNT_W   = 7;
  localparam int unsigned LAT_CNT_W   = 4;
  localparam int unsigned DATA_W      = 2 * RGB_W + ADDR_W;

  // FM6126 register writes are signalled by the number of clocks latch stays high
  localparam int unsigned LAT_R1 = 11;
  localparam int unsigned LAT_R2 = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_STREAM  = 2'd2
  } rx_state_t;

  typedef struct packed {
    logic [RGB_W-1:0] rgb0;
    logic [RGB_W-1:0] rgb1;
  } pix_t;

endpackage

// File: rtl/led_panel_receiver_if.sv
// Row pixel stream: valid/ready handshake carrying one column per beat.
interface led_panel_receiver_if;
  import led_panel_receiver_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [X_W-1:0]    out_x;
  logic [ADDR_W-1:0] out_addr;
  logic [RGB_W-1:0]  out_rgb0;
  logic [RGB_W-1:0]  out_rgb1;

  modport master (output out_valid, out_x, out_addr, out_rgb0, out_rgb1, input out_ready);
  modport slave  (input out_valid, out_x, out_addr, out_rgb0, out_rgb1, output out_ready);

endinterface

// File: rtl/led_panel_receiver_sync_edge.sv
// Multi-flop synchronizer for one asynchronous strobe plus rise/fall detect from one extra flop.
module led_panel_receiver_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level  = sync_q[SYNC_STAGES-1];
  assign rise_c = level & ~prev_q;
  assign fall_c = ~level & prev_q;

endmodule

// File: rtl/led_panel_receiver.sv
// HUB75 panel-side receiver: shifts columns, decodes FM6126 register writes, streams latched rows.
module led_panel_receiver
  import led_panel_receiver_pkg::*;
#(
  parameter int unsigned PANEL_W     = PANEL_W_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [RGB_W-1:0]     hub_rgb0,
  input  logic [RGB_W-1:0]     hub_rgb1,
  input  logic [ADDR_W-1:0]    hub_addr,
  input  logic                 hub_blank,
  input  logic                 hub_latch,
  input  logic                 hub_sclk,
  led_panel_receiver_if.master stream,
  output logic                 reg_wr,
  output logic                 reg_sel,
  output logic [REG_W-1:0]     reg_data,
  output logic                 panel_blank,
  output logic                 row_len_err,
  output logic                 overrun,
  output logic                 latch_err
);

  localparam int unsigned IDX_W = (PANEL_W > 1) ? $clog2(PANEL_W) : 1;

  // Strobe synchronizers
  logic sclk_lvl, sclk_rise_c, sclk_fall_c;
  logic latch_lvl, latch_rise_c, latch_fall_c;
  logic blank_rise_c, blank_fall_c;

  led_panel_receiver_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .resetn(resetn), .d(hub_sclk),
    .level(sclk_lvl), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c));

  led_panel_receiver_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
    .clk(clk), .resetn(resetn), .d(hub_latch),
    .level(latch_lvl), .rise_c(latch_rise_c), .fall_c(latch_fall_c));

  led_panel_receiver_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_blank (
    .clk(clk), .resetn(resetn), .d(hub_blank),
    .level(panel_blank), .rise_c(blank_rise_c), .fall_c(blank_fall_c));

  logic unused_edges;
  assign unused_edges = ^{sclk_lvl, sclk_fall_c, latch_rise_c, blank_rise_c};

  // Data bits share the strobe synchronizer depth so they line up with the sclk edge
  logic [SYNC_STAGES-1:0][DATA_W-1:0] data_sync_q;
  logic [DATA_W-1:0]                  data_s;
  pix_t                               pix_s;
  logic [ADDR_W-1:0]                  addr_s;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) data_sync_q <= '0;
    else         data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], hub_rgb0, hub_rgb1, hub_addr};
  end

  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign pix_s  = pix_t'(data_s[DATA_W-1:ADDR_W]);
  assign addr_s = data_s[ADDR_W-1:0];

  // Counters and shadow including this cycle's sclk edge, so a coincident latch fall sees it
  logic [COL_CNT_W-1:0] col_cnt_q, col_inc_c;
  logic [LAT_CNT_W-1:0] lat_cnt_q, lat_inc_c;
  logic [REG_W-1:0]     shadow_q, shadow_inc_c;

  always_comb begin
    col_inc_c    = col_cnt_q;
    lat_inc_c    = lat_cnt_q;
    shadow_inc_c = shadow_q;
    if (sclk_rise_c) begin
      if (col_cnt_q != '1)              col_inc_c = col_cnt_q + COL_CNT_W'(1);
      if (latch_lvl && lat_cnt_q != '1) lat_inc_c = lat_cnt_q + LAT_CNT_W'(1);
      shadow_inc_c = {shadow_q[REG_W-2:0], pix_s.rgb0[0]};
    end
  end

  logic is_r1_c, is_r2_c, row_latch_c, lat_bad_c;
  assign is_r1_c     = latch_fall_c && (lat_inc_c == LAT_CNT_W'(LAT_R1));
  assign is_r2_c     = latch_fall_c && (lat_inc_c == LAT_CNT_W'(LAT_R2));
  assign row_latch_c = latch_fall_c && (lat_inc_c == '0);
  assign lat_bad_c   = latch_fall_c && !(is_r1_c || is_r2_c || row_latch_c);

  // Column shift buffer and latched row buffer (no reset needed on contents)
  pix_t [PANEL_W-1:0] shift_buf_q, shift_nxt_c, row_buf_q;
  logic               capture_c;

  assign shift_nxt_c = sclk_rise_c ? {pix_s, shift_buf_q[PANEL_W-1:1]} : shift_buf_q;

  always_ff @(posedge clk) begin
    shift_buf_q <= shift_nxt_c;
    if (capture_c) row_buf_q <= shift_nxt_c;
  end

  // FSM state and registered stream outputs
  rx_state_t         state_q, state_nxt;
  logic              valid_q, valid_nxt;
  logic [X_W-1:0]    x_q, x_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  pix_t              pix_q, pix_nxt;

  always_comb begin
    state_nxt = state_q;
    valid_nxt = valid_q;
    x_nxt     = x_q;
    addr_nxt  = addr_q;
    pix_nxt   = pix_q;
    capture_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (row_latch_c) begin
          capture_c = 1'b1;
          state_nxt = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (blank_fall_c) begin
          state_nxt = ST_STREAM;
          addr_nxt  = addr_s;
          valid_nxt = 1'b1;
          x_nxt     = '0;
          pix_nxt   = row_buf_q[0];
        end
      end
      ST_STREAM: begin
        if (valid_q && stream.out_ready) begin
          if (x_q == X_W'(PANEL_W - 1)) begin
            valid_nxt = 1'b0;
            state_nxt = ST_IDLE;
          end else begin
            x_nxt   = x_q + X_W'(1);
            pix_nxt = row_buf_q[IDX_W'(x_nxt)];
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      valid_q     <= 1'b0;
      x_q         <= '0;
      addr_q      <= '0;
      pix_q       <= '0;
      col_cnt_q   <= '0;
      lat_cnt_q   <= '0;
      shadow_q    <= '0;
      reg_wr      <= 1'b0;
      reg_sel     <= 1'b0;
      reg_data    <= '0;
      row_len_err <= 1'b0;
      overrun     <= 1'b0;
      latch_err   <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      valid_q     <= valid_nxt;
      x_q         <= x_nxt;
      addr_q      <= addr_nxt;
      pix_q       <= pix_nxt;
      col_cnt_q   <= latch_fall_c ? '0 : col_inc_c;
      lat_cnt_q   <= latch_fall_c ? '0 : lat_inc_c;
      shadow_q    <= shadow_inc_c;
      reg_wr      <= is_r1_c || is_r2_c;
      if (is_r1_c || is_r2_c) begin
        reg_sel  <= is_r2_c;
        reg_data <= shadow_inc_c;
      end
      row_len_err <= row_latch_c && (col_inc_c != COL_CNT_W'(PANEL_W));
      overrun     <= row_latch_c && (state_q != ST_IDLE);
      latch_err   <= lat_bad_c;
    end
  end

  assign stream.out_valid = valid_q;
  assign stream.out_x     = x_q;
  assign stream.out_addr  = addr_q;
  assign stream.out_rgb0  = pix_q.rgb0;
  assign stream.out_rgb1  = pix_q.rgb1;

endmodule

// File: tb/tb_led_panel_receiver.sv
// Scoreboard bench for led_panel_receiver: HUB75 shift/latch/blank stimulus, beat and register-write checks.
module tb_led_panel_receiver;
  import led_panel_receiver_pkg::*;

  logic              clk = 1'b0;
  logic              resetn;
  logic [RGB_W-1:0]  hub_rgb0, hub_rgb1;
  logic [ADDR_W-1:0] hub_addr;
  logic              hub_blank, hub_latch, hub_sclk;
  logic              reg_wr, reg_sel;
  logic [REG_W-1:0]  reg_data;
  logic              panel_blank, row_len_err, overrun, latch_err;

  led_panel_receiver_if rx_if ();

  led_panel_receiver dut (
    .clk(clk), .resetn(resetn),
    .hub_rgb0(hub_rgb0), .hub_rgb1(hub_rgb1), .hub_addr(hub_addr),
    .hub_blank(hub_blank), .hub_latch(hub_latch), .hub_sclk(hub_sclk),
    .stream(rx_if),
    .reg_wr(reg_wr), .reg_sel(reg_sel), .reg_data(reg_data),
    .panel_blank(panel_blank), .row_len_err(row_len_err),
    .overrun(overrun), .latch_err(latch_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_rle = 0;
  int n_ovr = 0;
  int n_lerr = 0;

  logic [16:0] sb_q[$];      // {x, addr, rgb0, rgb1}
  logic [16:0] reg_q[$];     // {sel, data}
  logic [5:0]  model_q[$];   // last PANEL_W shifted columns, oldest first
  logic [5:0]  pend_row [PANEL_W_DEF];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: beats against the scoreboard, register writes, error pulse counts
  always @(negedge clk) begin
    logic [31:0] exp_v;
    if (rx_if.out_valid && rx_if.out_ready) begin
      exp_v = 32'h8000_0000;
      if (sb_q.size() != 0) exp_v = 32'(sb_q.pop_front());
      chk("beat", 32'({rx_if.out_x, rx_if.out_addr, rx_if.out_rgb0, rx_if.out_rgb1}), exp_v);
    end
    if (reg_wr) begin
      exp_v = 32'h8000_0000;
      if (reg_q.size() != 0) exp_v = 32'(reg_q.pop_front());
      chk("reg_wr", 32'({reg_sel, reg_data}), exp_v);
    end
    if (row_len_err) n_rle++;
    if (overrun)     n_ovr++;
    if (latch_err)   n_lerr++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_col(input logic [2:0] r0, input logic [2:0] r1, input logic lat);
    hub_rgb0  = r0;
    hub_rgb1  = r1;
    hub_latch = lat;
    cyc(3);
    hub_sclk = 1'b1;
    cyc(3);
    hub_sclk = 1'b0;
    model_q.push_back({r0, r1});
    if (model_q.size() > PANEL_W_DEF) void'(model_q.pop_front());
  endtask

  task automatic shift_row(input int ncols, input bit rnd);
    logic [2:0] r0;
    for (int k = 0; k < ncols; k++) begin
      r0 = rnd ? 3'($urandom_range(0, 7)) : 3'(k);
      shift_col(r0, rnd ? 3'($urandom_range(0, 7)) : ~r0, 1'b0);
    end
  endtask

  task automatic latch_pulse();
    hub_latch = 1'b1;
    cyc(3);
    hub_latch = 1'b0;
    cyc(6);
  endtask

  task automatic snap_row();
    for (int i = 0; i < PANEL_W_DEF; i++) pend_row[i] = model_q[i];
  endtask

  task automatic blank_fall(input logic [4:0] addr);
    for (int i = 0; i < PANEL_W_DEF; i++) sb_q.push_back({6'(i), addr, pend_row[i]});
    hub_addr  = addr;
    hub_blank = 1'b0;
    cyc(1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb_q.size() != 0 && n < 3000) begin
      cyc(1);
      n++;
    end
    chk({tag, "_drain"}, 32'(sb_q.size()), 0);
    cyc(2);
    chk({tag, "_valid_off"}, 32'(rx_if.out_valid), 0);
    hub_blank = 1'b1;
    cyc(4);
  endtask

  task automatic fm_seq(input logic [15:0] val, input int nlat);
    for (int k = 0; k < 64; k++) shift_col({2'b00, val[15 - (k % 16)]}, 3'b000, k >= 64 - nlat);
    hub_latch = 1'b0;
    cyc(6);
  endtask

  task automatic wait_x(input logic [5:0] xv, output bit found);
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(posedge clk);
      #1;
      if (rx_if.out_valid && rx_if.out_x == xv) found = 1'b1;
    end
  endtask

  initial begin
    bit found;
    resetn = 1'b1;
    hub_rgb0 = '0; hub_rgb1 = '0; hub_addr = '0;
    hub_blank = 1'b1; hub_latch = 1'b0; hub_sclk = 1'b0;
    rx_if.out_ready = 1'b1;
    #1 resetn = 1'b0;
    cyc(4);
    chk("rst_valid", 32'(rx_if.out_valid), 0);
    chk("rst_x", 32'(rx_if.out_x), 0);
    chk("rst_addr", 32'(rx_if.out_addr), 0);
    chk("rst_rgb", 32'({rx_if.out_rgb0, rx_if.out_rgb1}), 0);
    chk("rst_reg", 32'({reg_wr, reg_sel, reg_data}), 0);
    chk("rst_err", 32'({row_len_err, overrun, latch_err}), 0);
    chk("rst_blank", 32'(panel_blank), 0);
    resetn = 1'b1;
    cyc(5);
    chk("blank_sync", 32'(panel_blank), 1);

    // Counting row, addr 5, with a 10-cycle stall at x=20
    shift_row(64, 1'b0);
    latch_pulse();
    snap_row();
    chk("rowA_rle", 32'(n_rle), 0);
    blank_fall(5'd5);
    wait_x(6'd20, found);
    chk("stall_seen", 32'(found), 1);
    rx_if.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("stall_x", 32'(rx_if.out_x), 20);
      chk("stall_rgb", 32'({rx_if.out_rgb0, rx_if.out_rgb1}), 32'(pend_row[20]));
    end
    rx_if.out_ready = 1'b1;
    drain("rowA");

    // Second row latched while the first is still streaming
    shift_row(64, 1'b1);
    latch_pulse();
    snap_row();
    rx_if.out_ready = 1'b0;
    blank_fall(5'd9);
    cyc(6);
    chk("ovr_valid", 32'(rx_if.out_valid), 1);
    shift_row(64, 1'b1);
    latch_pulse();
    chk("ovr_pulse", 32'(n_ovr), 1);
    chk("ovr_hold_x", 32'(rx_if.out_x), 0);
    rx_if.out_ready = 1'b1;
    drain("rowB");

    // Short row: error pulse, still captured and streamed
    shift_row(63, 1'b1);
    latch_pulse();
    snap_row();
    chk("short_rle", 32'(n_rle), 1);
    blank_fall(5'd17);
    drain("rowD");

    // FM6126 register writes
    reg_q.push_back({1'b0, 16'h7FFF});
    fm_seq(16'h7FFF, 11);
    reg_q.push_back({1'b1, 16'h0040});
    fm_seq(16'h0040, 12);
    cyc(4);
    chk("reg_done", 32'(reg_q.size()), 0);
    chk("reg_no_lerr", 32'(n_lerr), 0);

    // Latch held for 5 edges: error only
    for (int k = 0; k < 16; k++) shift_col(3'(k), 3'(k), k >= 11);
    hub_latch = 1'b0;
    cyc(6);
    chk("lerr_pulse", 32'(n_lerr), 1);
    chk("lerr_rle", 32'(n_rle), 1);

    // Reset mid-stream at x=30
    shift_row(64, 1'b1);
    latch_pulse();
    snap_row();
    blank_fall(5'd3);
    wait_x(6'd30, found);
    chk("x30_seen", 32'(found), 1);
    resetn = 1'b0;
    #1;
    sb_q.delete();
    chk("rst_mid_valid", 32'(rx_if.out_valid), 0);
    chk("rst_mid_x", 32'(rx_if.out_x), 0);
    cyc(3);
    resetn = 1'b1;
    hub_blank = 1'b1;
    cyc(5);
    hub_blank = 1'b0;
    cyc(20);
    chk("post_rst_idle", 32'(rx_if.out_valid), 0);
    hub_blank = 1'b1;
    cyc(4);

    // Recovery row
    shift_row(64, 1'b1);
    latch_pulse();
    snap_row();
    blank_fall(5'd31);
    drain("rowF");

    chk("final_ovr", 32'(n_ovr), 1);
    chk("final_rle", 32'(n_rle), 1);
    chk("final_lerr", 32'(n_lerr), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
